axi_wr_arbiter: RTL
===================

AXI_WR_ARBITER -- requirements
Module: axi_wr_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 3, giving the number of requesting masters (2..8).
REQ-002 SHALL have parameter AW_BITS, default 49, giving the AW payload width {id[7:0], addr[31:0], len[3:0], size[2:0], burst[1:0]}.
REQ-003 SHALL have parameter W_BITS, default 37, giving the W payload width {data[31:0], strb[3:0], last}.
REQ-004 SHALL have one clock and a synchronous, active-high reset: AXI_CLK_i  in  1  clock; AXI_RST_i  in  1  reset.
REQ-005 SHALL have port AW_REQ_i  in  N_MST  per-master AW FIFO non-empty and decoded to this slave.
REQ-006 SHALL have port AW_DATA_i  in  N_MST*AW_BITS  master m payload at [m*AW_BITS +: AW_BITS].
REQ-007 SHALL have port AW_POP_o  out  N_MST  one-hot pop to the granted master's AW FIFO.
REQ-008 SHALL have port W_VALID_i  in  N_MST  per-master W FIFO non-empty.
REQ-009 SHALL have port W_DATA_i  in  N_MST*W_BITS  master m payload at [m*W_BITS +: W_BITS].
REQ-010 SHALL have port W_POP_o  out  N_MST  one-hot W FIFO pop.
REQ-011 SHALL have ports AWVALID_o out 1, AWREADY_i in 1, AW_o out AW_BITS (slave AW channel).
REQ-012 SHALL have ports WVALID_o out 1, WREADY_i in 1, W_o out W_BITS (slave W channel).
REQ-013 SHALL have ports BVALID_i in 1, BID_i in 8, BRESP_i in 2, BREADY_o out 1 (slave B channel).
REQ-014 SHALL have ports BVALID_o out N_MST (one-hot), BID_o out 8, BRESP_o out 2, BREADY_i in N_MST (master B return).
REQ-015 SHALL have port GRANT_o  out  N_MST  one-hot current owner, zero in IDLE.

Function
REQ-016 SHALL implement FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; the write path is owned by exactly one master from grant until its B handshake.
REQ-017 In IDLE, if AW_REQ_i != 0, grant SHALL be registered; the FSM enters ADDR and AWVALID_o rises the next cycle (1-cycle latency).
REQ-018 Grant SHALL be round-robin: search starts at pointer ptr, ascending and wrapping modulo N_MST; ptr = 0 after reset.
REQ-019 In ADDR, AWVALID_o SHALL be 1 and AW_o SHALL equal the granted master's AW_DATA_i slice.
REQ-020 On AWVALID_o&AWREADY_i, the FSM SHALL pulse AW_POP_o[g] for that cycle only, latch len, clear beat counter, and enter DATA.
REQ-021 In DATA: WVALID_o = W_VALID_i[g]; W_O = granted W slice, except W_o[0] (last) SHALL be forced to (beat == len).
REQ-022 In DATA, W_POP_o[g] SHALL equal WVALID_o&WREADY_i, and each such handshake SHALL increment the 4-bit beat counter.
REQ-023 A handshake with beat == len SHALL enter RESP; the master's own last bit SHALL be ignored for sequencing (len 15 = 16 beats, no counter overflow).
REQ-024 In RESP: BREADY_o = BREADY_i[g], BVALID_o[g] = BVALID_i, BID_o = BID_i, BRESP_o = BRESP_i; all other BVALID_o bits SHALL be 0.
REQ-025 On BVALID_i&BREADY_o, the FSM SHALL go to IDLE and set ptr = (g+1) mod N_MST.
REQ-026 When not in the owning state, AWVALID_o, WVALID_o, BREADY_o, BVALID_o, AW_POP_o and W_POP_o SHALL be 0; slave B activity outside RESP SHALL be ignored.
REQ-027 AW_REQ_i and W_VALID_i of non-granted masters SHALL NOT affect any output while the path is owned.
REQ-028 Back-to-back operation: after a B handshake in cycle t, the next AWVALID_o SHALL be asserted no earlier than t+2.

Reset
REQ-029 While AXI_RST_i = 1 at a clock edge, the FSM SHALL be in IDLE, ptr = 0, beat = 0, and GRANT_o and every valid/ready/pop output SHALL be 0 the next cycle.
REQ-030 Reset mid-burst SHALL abandon the transaction without further pops; data outputs AW_o, W_o, BID_o and BRESP_o SHALL be 0 in IDLE.

Verification
REQ-031 Single master 0, len 0, AWREADY_i=WREADY_i=1 -> AWVALID_o at t+1, one W beat with W_o[0]=1, BVALID_o=001 on B, IDLE, ptr=1.
REQ-032 All three requesting continuously, len 1 each -> grant order 0,1,2,0, each with exactly 2 W_POP_o pulses and 1 AW_POP_o pulse.
REQ-033 Master 1, len 15, WREADY_i toggling 1/0 -> 16 W handshakes, last only on 16th, beat counter wraps cleanly to RESP.
REQ-034 Master 2 W_DATA last bit set on beat 0 of len 3 -> W_o[0]=0 for beats 0-2, 1 on beat 3; FSM stays DATA until beat 3.
REQ-035 AXI_RST_i asserted in DATA after 2 of 4 beats -> next cycle IDLE, all pops 0, GRANT_o=0; next grant from master 0.
REQ-036 BVALID_i pulsed while in ADDR -> BVALID_o stays 0, BREADY_o 0, FSM unaffected.

Source files
------------

// File: rtl/axi_wr_arbiter.sv
// Round-robin N-master to one-slave AXI write arbiter.
// One master owns the AW/W/B path from grant until its B handshake completes.
module axi_wr_arbiter #(
  parameter int unsigned N_MST   = 3,
  parameter int unsigned AW_BITS = 49,
  parameter int unsigned W_BITS  = 37
) (
  input  logic                       AXI_CLK_i,
  input  logic                       AXI_RST_i,
  input  logic [N_MST-1:0]           AW_REQ_i,
  input  logic [N_MST*AW_BITS-1:0]   AW_DATA_i,
  output logic [N_MST-1:0]           AW_POP_o,
  input  logic [N_MST-1:0]           W_VALID_i,
  input  logic [N_MST*W_BITS-1:0]    W_DATA_i,
  output logic [N_MST-1:0]           W_POP_o,
  output logic                       AWVALID_o,
  input  logic                       AWREADY_i,
  output logic [AW_BITS-1:0]         AW_o,
  output logic                       WVALID_o,
  input  logic                       WREADY_i,
  output logic [W_BITS-1:0]          W_o,
  input  logic                       BVALID_i,
  input  logic [7:0]                 BID_i,
  input  logic [1:0]                 BRESP_i,
  output logic                       BREADY_o,
  output logic [N_MST-1:0]           BVALID_o,
  output logic [7:0]                 BID_o,
  output logic [1:0]                 BRESP_o,
  input  logic [N_MST-1:0]           BREADY_i,
  output logic [N_MST-1:0]           GRANT_o
);

  localparam int unsigned IW      = (N_MST > 1) ? $clog2(N_MST) : 1;
  localparam int unsigned LEN_LSB = 5;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t             state_q, state_d;
  logic [N_MST-1:0]   grant_q, grant_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         beat_q, beat_d;
  logic [AW_BITS-1:0] aw_sel;
  logic [W_BITS-1:0]  w_sel;
  logic [IW-1:0]      rr_idx;
  logic               rr_hit;

  assign GRANT_o = grant_q;

  // Payload slices of the current owner
  always_comb begin
    aw_sel = '0;
    w_sel  = '0;
    for (int unsigned m = 0; m < N_MST; m++) begin
      if (gidx_q == IW'(m)) begin
        aw_sel = AW_DATA_i[m*AW_BITS +: AW_BITS];
        w_sel  = W_DATA_i[m*W_BITS +: W_BITS];
      end
    end
  end

  // Round-robin search starting at ptr, wrapping modulo N_MST
  always_comb begin
    int unsigned c;
    rr_hit = 1'b0;
    rr_idx = ptr_q;
    c      = 0;
    for (int unsigned i = 0; i < N_MST; i++) begin
      c = 32'(ptr_q) + i;
      if (c >= N_MST) c = c - N_MST;
      if (!rr_hit && AW_REQ_i[IW'(c)]) begin
        rr_hit = 1'b1;
        rr_idx = IW'(c);
      end
    end
  end

  always_ff @(posedge AXI_CLK_i) begin
    if (AXI_RST_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
    end
  end

  // Next state and channel steering; reset suppresses every handshake
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    gidx_d    = gidx_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    beat_d    = beat_q;
    AWVALID_o = 1'b0;
    AW_o      = '0;
    AW_POP_o  = '0;
    WVALID_o  = 1'b0;
    W_o       = '0;
    W_POP_o   = '0;
    BREADY_o  = 1'b0;
    BVALID_o  = '0;
    BID_o     = '0;
    BRESP_o   = '0;
    if (!AXI_RST_i) begin
      case (state_q)
        IDLE: begin
          if (rr_hit) begin
            grant_d         = '0;
            grant_d[rr_idx] = 1'b1;
            gidx_d          = rr_idx;
            state_d         = ADDR;
          end
        end
        ADDR: begin
          AWVALID_o = 1'b1;
          AW_o      = aw_sel;
          if (AWREADY_i) begin
            AW_POP_o[gidx_q] = 1'b1;
            len_d            = aw_sel[LEN_LSB +: 4];
            beat_d           = '0;
            state_d          = DATA;
          end
        end
        DATA: begin
          // The master's own last flag is replaced by the beat count
          WVALID_o = W_VALID_i[gidx_q];
          W_o      = {w_sel[W_BITS-1:1], (beat_q == len_q)};
          if (WVALID_o && WREADY_i) begin
            W_POP_o[gidx_q] = 1'b1;
            beat_d          = beat_q + 4'd1;
            if (beat_q == len_q) state_d = RESP;
          end
        end
        RESP: begin
          BREADY_o         = BREADY_i[gidx_q];
          BVALID_o[gidx_q] = BVALID_i;
          BID_o            = BID_i;
          BRESP_o          = BRESP_i;
          if (BVALID_i && BREADY_o) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (gidx_q == IW'(N_MST - 1)) ? '0 : gidx_q + IW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
